// File: rtl/axis_pkt_checker_pkg.sv
// ============================================================================
// axis_pkt_checker_pkg : LFSR taps, next-value function and FSM state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package axis_pkt_checker_pkg;

    // Feedback taps at bits 31, 21, 1 and 0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Narrower LFSRs use the low bits of the result; taps above the width see zero
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_checker_sat_counter16.sv
// ============================================================================
// sat_counter16 : 16-bit counter with synchronous clear, saturating at 16'hFFFF
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter16 (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_checker.sv
// ============================================================================
// axis_pkt_checker : AXI-Stream LFSR packet checker with packet/error counters.
// Optional TDEST check enabled by macro AXIS_PKT_CHECKER_DEST_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_pkt_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter int TDATAW    = 32,
    parameter int TDESTW    = 4,
    parameter int LFSR_DW   = 32,
    parameter int MAX_BEATS = 16,
    parameter int MY_ADDR   = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              CLEAR,
    input  logic              AXIS_S_TVALID,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_S_TREADY,
    output logic [15:0]       PKT_CNT,
    output logic [15:0]       ERR_CNT,
    output logic              ERR_FLAG,
    output logic [7:0]        LAST_LEN,
    output logic              BUSY
);

    state_t               state;
    logic [LFSR_DW-1:0]   expected;
    logic [7:0]           beats;
    logic                 pkt_err;

    logic                 hs;
    logic                 complete;
    logic [LFSR_DW-1:0]   data;
    logic [31:0]          next_exp32;
    logic [LFSR_DW-1:0]   next_exp;
    logic [7:0]           beats_inc;
    logic [7:0]           done_len;
    logic                 dest_err;
    logic                 beat_err;
    logic                 err_inc;

    assign AXIS_S_TREADY = ENABLE;
    assign hs            = AXIS_S_TVALID & ENABLE;
    assign complete      = hs & AXIS_S_TLAST;
    assign data          = AXIS_S_TDATA[LFSR_DW-1:0];
    assign next_exp32    = lfsr_next(32'(data));
    assign next_exp      = next_exp32[LFSR_DW-1:0];
    assign beats_inc     = beats + 8'd1;
    assign BUSY          = (state != ST_IDLE);

    generate
        if (TDATAW > LFSR_DW) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^AXIS_S_TDATA[TDATAW-1:LFSR_DW];
        end
    endgenerate

`ifdef AXIS_PKT_CHECKER_DEST_CHECK_EN
    assign dest_err = (AXIS_S_TDEST != TDESTW'(MY_ADDR));
`else
    logic [TDESTW-1:0] unused_dest;
    assign unused_dest = AXIS_S_TDEST ^ TDESTW'(MY_ADDR);
    assign dest_err    = 1'b0;
`endif

    // Data is compared only in BODY; the seed and drained beats are never checked
    always_comb begin
        beat_err = dest_err;
        if ((state == ST_BODY) && (data != expected)) begin
            beat_err = 1'b1;
        end
    end

    always_comb begin
        case (state)
            ST_IDLE: done_len = 8'd1;
            ST_BODY: done_len = beats_inc;
            default: done_len = beats;
        endcase
    end

    assign err_inc = complete & (pkt_err | beat_err);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            expected <= '0;
            beats    <= 8'd0;
            pkt_err  <= 1'b0;
            LAST_LEN <= 8'd0;
            ERR_FLAG <= 1'b0;
        end else begin
            if (hs) begin
                case (state)
                    ST_IDLE: begin
                        expected <= next_exp;
                        beats    <= 8'd1;
                        if (AXIS_S_TLAST) begin
                            pkt_err <= 1'b0;
                        end else begin
                            pkt_err <= beat_err;
                            state   <= ST_BODY;
                        end
                    end
                    ST_BODY: begin
                        expected <= next_exp;
                        beats    <= beats_inc;
                        if (AXIS_S_TLAST) begin
                            pkt_err <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (beats_inc == 8'(MAX_BEATS)) begin
                            pkt_err <= 1'b1;
                            state   <= ST_DRAIN;
                        end else begin
                            pkt_err <= pkt_err | beat_err;
                        end
                    end
                    ST_DRAIN: begin
                        if (AXIS_S_TLAST) begin
                            pkt_err <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            pkt_err <= pkt_err | beat_err;
                        end
                    end
                    default: begin
                        pkt_err <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end

            if (CLEAR) begin
                LAST_LEN <= 8'd0;
                ERR_FLAG <= 1'b0;
            end else if (complete) begin
                LAST_LEN <= done_len;
                if (pkt_err | beat_err) begin
                    ERR_FLAG <= 1'b1;
                end
            end
        end
    end

    sat_counter16 u_pkt_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (CLEAR),
        .inc   (complete),
        .cnt   (PKT_CNT)
    );

    sat_counter16 u_err_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (CLEAR),
        .inc   (err_inc),
        .cnt   (ERR_CNT)
    );

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_checker.sv
// ============================================================================
// tb_axis_pkt_checker : directed self-checking bench for axis_pkt_checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_pkt_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tdest;
    logic        tready;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic [7:0]  last_len;
    logic        busy;

    int tests;
    int fails;

    axis_pkt_checker #(
        .TDATAW    (32),
        .TDESTW    (4),
        .LFSR_DW   (32),
        .MAX_BEATS (4),
        .MY_ADDR   (1)
    ) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .ENABLE        (enable),
        .CLEAR         (clear),
        .AXIS_S_TVALID (tvalid),
        .AXIS_S_TDATA  (tdata),
        .AXIS_S_TLAST  (tlast),
        .AXIS_S_TDEST  (tdest),
        .AXIS_S_TREADY (tready),
        .PKT_CNT       (pkt_cnt),
        .ERR_CNT       (err_cnt),
        .ERR_FLAG      (err_flag),
        .LAST_LEN      (last_len),
        .BUSY          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge; inputs change only there
    task automatic beat(input logic [31:0] d, input logic last);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag, input int p, input int e,
                               input int f, input int l);
        check({tag, ".pkt"},  32'(pkt_cnt),  32'(p));
        check({tag, ".err"},  32'(err_cnt),  32'(e));
        check({tag, ".flag"}, 32'(err_flag), 32'(f));
        check({tag, ".len"},  32'(last_len), 32'(l));
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        tvalid = 1'b0;
        tdata  = 32'd0;
        tlast  = 1'b0;
        tdest  = 4'd1;

        repeat (2) @(negedge clk);
        check("rst.tready_en0", 32'(tready), 32'd0);
        enable = 1'b1;
        #1;
        check("rst.tready_en1", 32'(tready), 32'd1);
        check_stats("rst", 0, 0, 0, 0);
        check("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean 4-beat packet: 1 -> 3 -> 6 -> D
        beat(32'h1, 1'b0);
        check("clean.busy", 32'(busy), 32'd1);
        beat(32'h3, 1'b0);
        beat(32'h6, 1'b0);
        beat(32'hD, 1'b1);
        check_stats("clean", 1, 0, 0, 4);
        check("clean.idle", 32'(busy), 32'd0);
        idle();

        // Third beat corrupted
        beat(32'h1, 1'b0);
        beat(32'h3, 1'b0);
        beat(32'h7, 1'b0);
        beat(32'hD, 1'b1);
        check_stats("bad", 2, 1, 1, 4);
        idle();

        clear = 1'b1;
        idle();
        clear = 1'b0;
        check_stats("clear1", 0, 0, 0, 0);

        // 6-beat packet with MAX_BEATS=4: drains after beat 4
        beat(32'h1, 1'b0);
        beat(32'h3, 1'b0);
        beat(32'h6, 1'b0);
        beat(32'hD, 1'b0);
        check("ovf.busy", 32'(busy), 32'd1);
        check("ovf.tready", 32'(tready), 32'd1);
        check("ovf.pkt_mid", 32'(pkt_cnt), 32'd0);
        beat(32'h1B, 1'b0);
        check("ovf.tready2", 32'(tready), 32'd1);
        beat(32'h36, 1'b1);
        check_stats("ovf", 1, 1, 1, 4);
        idle();

        clear = 1'b1;
        idle();
        clear = 1'b0;
        check_stats("clear2", 0, 0, 0, 0);

        // ENABLE low for 3 cycles with TVALID held
        beat(32'h1, 1'b0);
        beat(32'h3, 1'b0);
        enable = 1'b0;
        tvalid = 1'b1;
        tdata  = 32'h6;
        for (int i = 0; i < 3; i++) begin
            check("stall.tready", 32'(tready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("stall.busy", 32'(busy), 32'd1);
        enable = 1'b1;
        beat(32'h6, 1'b0);
        beat(32'hD, 1'b1);
        check_stats("stall", 1, 0, 0, 4);
        idle();

        // Reset after 2 beats, then a fresh packet 5 -> B -> 16
        beat(32'h1, 1'b0);
        beat(32'h3, 1'b0);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        #2;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.pkt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(32'h5, 1'b0);
        beat(32'hB, 1'b0);
        beat(32'h16, 1'b1);
        check_stats("rstpkt", 1, 0, 0, 3);
        idle();

        // Single-beat packet
        beat(32'h55, 1'b1);
        check_stats("single", 2, 0, 0, 1);
        idle();

        // Zero seed predicts zero
        beat(32'h0, 1'b0);
        beat(32'h0, 1'b1);
        check_stats("zero", 3, 0, 0, 2);
        idle();

        // Error on last beat only
        beat(32'h1, 1'b0);
        beat(32'h4, 1'b1);
        check_stats("lastbad", 4, 1, 1, 2);
        idle();

        // CLEAR coincident with completion of a bad packet: CLEAR wins
        beat(32'h1, 1'b0);
        clear = 1'b1;
        beat(32'h7, 1'b1);
        clear = 1'b0;
        check_stats("clrcomp", 0, 0, 0, 0);
        check("clrcomp.busy", 32'(busy), 32'd0);
        idle();

        // TDEST mismatch
        tdest = 4'd2;
        beat(32'h1, 1'b0);
        beat(32'h3, 1'b1);
        tdest = 4'd1;
`ifdef AXIS_PKT_CHECKER_DEST_CHECK_EN
        check_stats("dest", 1, 1, 1, 2);
`else
        check_stats("dest", 1, 0, 0, 2);
`endif
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
